// File: rtl/lc3_trace_pkg.sv
// Shared codes for the LC-3 trace recorder: capture modes, recorder states, entry width.
// Define TRACE_TIMESTAMP_EN to prepend a 32-bit cycle stamp to every entry.
package lc3_trace_pkg;

    localparam logic [1:0] MODE_WRAP     = 2'd0;
    localparam logic [1:0] MODE_ONESHOT  = 2'd1;
    localparam logic [1:0] MODE_TRIG     = 2'd2;
    localparam logic [1:0] MODE_WRAP_ALT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    localparam logic [5:0] FETCH_CODE = 6'd18;

`ifdef TRACE_TIMESTAMP_EN
    localparam int TS_W = 32;
`else
    localparam int TS_W = 0;
`endif

    // {[ts], instr16, cur_state6, R[reg_count-1..0]}
    function automatic int entry_w(input int reg_count);
        return TS_W + 22 + 16 * reg_count;
    endfunction

endpackage

// File: rtl/lc3_trace_ram.sv
// Trace storage: one synchronous write port, one asynchronous read port, array not reset.
module lc3_trace_ram #(
    parameter int DEPTH = 32,
    parameter int W     = 150,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lc3_trace_capture.sv
// Per-instruction LC-3 trace recorder: captures one entry per FETCH entry into a circular buffer.
// Optional TRACE_TIMESTAMP_EN adds a free-running 32-bit cycle stamp to each entry.
module lc3_trace_capture
    import lc3_trace_pkg::*;
#(
    parameter int         DEPTH       = 32,
    parameter int         REG_COUNT   = 8,
    parameter logic [5:0] FETCH_STATE = FETCH_CODE,
    localparam int        ENTRY_W     = entry_w(REG_COUNT),
    localparam int        PW          = $clog2(DEPTH),
    localparam int        CW          = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [15:0]             debugInstruction,
    input  logic [5:0]              debugCurrentState,
    input  logic [5:0]              debugNextState,
    input  logic [16*REG_COUNT-1:0] debugRegRead,
    input  logic [1:0]              cfg_mode,
    input  logic [15:0]             cfg_trig_instr,
    input  logic [15:0]             cfg_trig_mask,
    input  logic                    arm,
    input  logic                    stop,
    input  logic                    rd_ready,
    output logic                    rd_valid,
    output logic [ENTRY_W-1:0]      rd_data,
    output logic [CW-1:0]           count,
    output logic                    overflow,
    output logic                    busy,
    output trace_state_e            dbg_state
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Readout: rd_valid/rd_data transfer on a rising clk edge where both rd_valid and
    // rd_ready are high; rd_data stays stable while rd_valid is high and rd_ready is low.

    trace_state_e      state;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [5:0]        prev_next;
    logic [ENTRY_W-1:0] entry, ram_q;
    logic              fetch_hit, trig_hit, wrap_mode, we, rd_fire;

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] ts;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ts <= '0;
        else          ts <= ts + 32'd1;
    end
    assign entry = {ts, debugInstruction, debugCurrentState, debugRegRead};
`else
    assign entry = {debugInstruction, debugCurrentState, debugRegRead};
`endif

    // Rising edge of next_state==FETCH, so a FETCH lasting several cycles records once.
    assign fetch_hit = (debugNextState == FETCH_STATE) && (prev_next != FETCH_STATE);
    assign trig_hit  = fetch_hit && (((debugInstruction ^ cfg_trig_instr) & cfg_trig_mask) == 16'd0);
    assign wrap_mode = (cfg_mode == MODE_WRAP) || (cfg_mode == MODE_WRAP_ALT);
    assign we        = ((state == ST_RUN) && fetch_hit) || ((state == ST_ARMED) && trig_hit);
    assign rd_valid  = (state == ST_DONE) && (count != '0);
    assign rd_fire   = rd_valid && rd_ready;
    assign rd_data   = rd_valid ? ram_q : '0;
    assign busy      = (state == ST_ARMED) || (state == ST_RUN);
    assign dbg_state = state;

    lc3_trace_ram #(.DEPTH(DEPTH), .W(ENTRY_W)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (entry),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            prev_next <= '0;
        end else begin
            prev_next <= debugNextState;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (arm && !stop) begin
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                        state    <= (cfg_mode == MODE_TRIG) ? ST_ARMED : ST_RUN;
                    end else if (rd_fire) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        count  <= count - 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (trig_hit) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        count  <= count + 1'b1;
                    end
                    if (stop)          state <= ST_DONE;
                    else if (trig_hit) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (fetch_hit) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (count == FULL) begin
                            // Full in wrap mode: the new entry replaces the oldest.
                            rd_ptr   <= rd_ptr + 1'b1;
                            overflow <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    if (stop || (!wrap_mode && fetch_hit && (count == FULL - 1'b1)))
                        state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_trace_capture.sv
// Scoreboard bench for lc3_trace_capture: directed instruction streams, expected entries queued, monitor checks readout.
module tb_lc3_trace_capture;
  import lc3_trace_pkg::*;

  localparam int DEPTH = 4;
  localparam int REGS  = 2;
  localparam int EW    = entry_w(REGS);
  localparam int CMPW  = 22 + 16 * REGS;
  localparam int CW    = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset_n;
  logic [15:0]       debugInstruction;
  logic [5:0]        debugCurrentState;
  logic [5:0]        debugNextState;
  logic [16*REGS-1:0] debugRegRead;
  logic [1:0]        cfg_mode;
  logic [15:0]       cfg_trig_instr;
  logic [15:0]       cfg_trig_mask;
  logic              arm, stop, rd_ready;
  logic              rd_valid;
  logic [EW-1:0]     rd_data;
  logic [CW-1:0]     count;
  logic              overflow, busy;
  trace_state_e      dbg_state;

  logic [CMPW-1:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  lc3_trace_capture #(.DEPTH(DEPTH), .REG_COUNT(REGS)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .debugInstruction  (debugInstruction),
    .debugCurrentState (debugCurrentState),
    .debugNextState    (debugNextState),
    .debugRegRead      (debugRegRead),
    .cfg_mode          (cfg_mode),
    .cfg_trig_instr    (cfg_trig_instr),
    .cfg_trig_mask     (cfg_trig_mask),
    .arm               (arm),
    .stop              (stop),
    .rd_ready          (rd_ready),
    .rd_valid          (rd_valid),
    .rd_data           (rd_data),
    .count             (count),
    .overflow          (overflow),
    .busy              (busy),
    .dbg_state         (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] regs_of(input logic [15:0] ir);
    return {~ir, ir};
  endfunction

  function automatic logic [CMPW-1:0] entry_of(input logic [15:0] ir);
    return {ir, 6'd1, regs_of(ir)};
  endfunction

  // driver tasks
  task automatic pulse(input logic a, input logic s);
    @(negedge clk);
    arm = a;
    stop = s;
    @(negedge clk);
    arm = 1'b0;
    stop = 1'b0;
  endtask

  task automatic do_instr(input logic [15:0] ir, input int hold, input logic stop_on_hit);
    @(negedge clk);
    debugInstruction  = ir;
    debugRegRead      = regs_of(ir);
    debugCurrentState = 6'd1;
    debugNextState    = FETCH_CODE;
    stop              = stop_on_hit;
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      stop              = 1'b0;
      debugCurrentState = FETCH_CODE;
      debugNextState    = FETCH_CODE;
    end
    @(negedge clk);
    stop              = 1'b0;
    debugCurrentState = FETCH_CODE;
    debugNextState    = 6'd33;
    @(negedge clk);
    debugCurrentState = 6'd33;
    debugNextState    = 6'd35;
    @(negedge clk);
    debugCurrentState = 6'd35;
    debugNextState    = 6'd32;
    @(negedge clk);
    debugCurrentState = 6'd32;
    debugNextState    = 6'd1;
  endtask

  task automatic drain();
    bit done = 1'b0;
    @(negedge clk);
    rd_ready = 1'b1;
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge clk);
      #1;
      if (count == '0) done = 1'b1;
    end
    rd_ready = 1'b0;
    check("drain_done", done, 1'b1);
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_rd_valid", rd_valid, 1'b0);
  endtask

  // scoreboard monitor
  initial begin
    logic [CMPW-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL rd_unexpected: got %h, expected no entry", rd_data);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", rd_data[CMPW-1:0], e);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    debugInstruction = '0;
    debugCurrentState = 6'd0;
    debugNextState = 6'd0;
    debugRegRead = '0;
    cfg_mode = MODE_ONESHOT;
    cfg_trig_instr = '0;
    cfg_trig_mask = '0;
    arm = 1'b0;
    stop = 1'b0;
    rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("reset_state", dbg_state, ST_IDLE);
    check("reset_count", count, 0);
    check("reset_rd_valid", rd_valid, 1'b0);
    check("reset_rd_data", rd_data[CMPW-1:0], 0);
    check("reset_busy", busy, 1'b0);
    check("reset_overflow", overflow, 1'b0);

    // one-shot: stops after DEPTH entries, later instructions ignored
    cfg_mode = MODE_ONESHOT;
    pulse(1'b1, 1'b0);
    #1;
    check("os_state_run", dbg_state, ST_RUN);
    check("os_busy", busy, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      do_instr(16'h1000 + 16'(i), 1, 1'b0);
      #1;
      if (i == 3) check("os_count3", count, 3);
      if (i == 4) check("os_done_after4", dbg_state, ST_DONE);
    end
    check("os_count", count, 4);
    check("os_overflow", overflow, 1'b0);
    check("os_busy_done", busy, 1'b0);
    for (int i = 1; i <= 4; i++) exp_q.push_back(entry_of(16'h1000 + 16'(i)));
    drain();

    // wrap: oldest two overwritten, stays RUN until stop
    cfg_mode = MODE_WRAP;
    pulse(1'b1, 1'b0);
    for (int i = 1; i <= 6; i++) do_instr(16'h1200 + 16'(i), 1, 1'b0);
    #1;
    check("wrap_state_run", dbg_state, ST_RUN);
    check("wrap_count_run", count, 4);
    pulse(1'b0, 1'b1);
    #1;
    check("wrap_state_done", dbg_state, ST_DONE);
    check("wrap_overflow", overflow, 1'b1);
    check("wrap_count", count, 4);
    for (int i = 3; i <= 6; i++) exp_q.push_back(entry_of(16'h1200 + 16'(i)));
    drain();

    // triggered on BRnzp: preceding ADDs not recorded
    cfg_mode = MODE_TRIG;
    cfg_trig_instr = 16'h0E00;
    cfg_trig_mask = 16'hFE00;
    pulse(1'b1, 1'b0);
    #1;
    check("trig_armed", dbg_state, ST_ARMED);
    check("trig_overflow_cleared", overflow, 1'b0);
    do_instr(16'h1240, 1, 1'b0);
    do_instr(16'h1281, 1, 1'b0);
    #1;
    check("trig_still_armed", dbg_state, ST_ARMED);
    check("trig_count0", count, 0);
    do_instr(16'h0E05, 1, 1'b0);
    #1;
    check("trig_run", dbg_state, ST_RUN);
    do_instr(16'h1042, 1, 1'b0);
    pulse(1'b0, 1'b1);
    #1;
    check("trig_count", count, 2);
    exp_q.push_back(entry_of(16'h0E05));
    exp_q.push_back(entry_of(16'h1042));
    drain();

    // FETCH held 3 cycles with stop on the hit cycle: exactly one entry, then DONE
    cfg_mode = MODE_WRAP;
    pulse(1'b1, 1'b0);
    do_instr(16'h5020, 3, 1'b1);
    #1;
    check("hold_state_done", dbg_state, ST_DONE);
    check("hold_count", count, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("stall_rd_valid", rd_valid, 1'b1);
      check("stall_rd_data", rd_data[CMPW-1:0], entry_of(16'h5020));
    end
    exp_q.push_back(entry_of(16'h5020));
    drain();

    // reset in the middle of a capture, then a clean new capture
    pulse(1'b1, 1'b0);
    do_instr(16'h1111, 1, 1'b0);
    do_instr(16'h1222, 1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_state", dbg_state, ST_IDLE);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_count", count, 0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    cfg_mode = MODE_ONESHOT;
    pulse(1'b1, 1'b0);
    do_instr(16'h1333, 1, 1'b0);
    do_instr(16'h1444, 1, 1'b0);
    pulse(1'b0, 1'b1);
    #1;
    check("rst_new_count", count, 2);
    exp_q.push_back(entry_of(16'h1333));
    exp_q.push_back(entry_of(16'h1444));
    drain();

    // arm and stop together in DONE: stop wins, no restart
    pulse(1'b1, 1'b1);
    #1;
    check("armstop_state", dbg_state, ST_DONE);
    check("armstop_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
